// File: rtl/md_if.sv
// Operand/result bundle between the register-file read ports, the control unit
// and the iterative multiply/divide engine.
interface md_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_mult;
    logic                 is_unsigned;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;

    modport master (
        output start, a, b, is_mult, is_unsigned,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, a, b, is_mult, is_unsigned,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/md_iterative.sv
// Radix-2 iterative multiply/divide engine with MIPS HI/LO semantics:
// shift-add multiply, restoring divide, sign fix-up in a final cycle.
module md_iterative #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic clk,
    input logic rst,
    md_if.slave bus
);
    localparam int unsigned W2  = 2 * WIDTH;
    localparam int unsigned W2P = W2 + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2P-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              mult_q, mult_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              bz_q, bz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [W2-1:0]     result_q, result_d;

    // Operand magnitudes; |min_int| fits as an unsigned WIDTH-bit value.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign a_neg = ~bus.is_unsigned & bus.a[WIDTH-1];
    assign b_neg = ~bus.is_unsigned & bus.b[WIDTH-1];
    assign mag_a = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    assign mag_b = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

    // One shift-add multiply step: multiplier lives in the low half of acc.
    logic [WIDTH:0] mul_sum;
    logic [W2P-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_step = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);

    // One restoring divide step: acc holds {rem, quot}.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [W2P-1:0]   div_step;
    assign div_shift = acc_q[W2-1:WIDTH-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign div_ok    = (div_diff[WIDTH+1:WIDTH] == 2'b00);
    assign div_step  = div_ok ? {1'b0, div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                              : {1'b0, div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    // Sign correction; a zero divisor keeps the all-ones quotient untouched.
    logic [W2-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quot, rem, quot_fix, rem_fix;
    logic             neg_res;
    assign neg_res  = sign_a_q ^ sign_b_q;
    assign prod     = acc_q[W2-1:0];
    assign prod_fix = neg_res ? (~prod + W2'(1)) : prod;
    assign quot     = acc_q[WIDTH-1:0];
    assign rem      = acc_q[W2-1:WIDTH];
    assign quot_fix = (neg_res && !bz_q) ? (~quot + WIDTH'(1)) : quot;
    assign rem_fix  = sign_a_q ? (~rem + WIDTH'(1)) : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            mult_q   <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            mult_q   <= mult_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bz_q     <= bz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        mult_d   = mult_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bz_d     = bz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mult_d   = bus.is_mult;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    bz_d     = ~bus.is_mult & (bus.b == '0);
                    opnd_d   = bus.is_mult ? mag_a : mag_b;
                    acc_d    = {{(WIDTH+1){1'b0}}, (bus.is_mult ? mag_b : mag_a)};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = mult_q ? mul_step : div_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = mult_q ? prod_fix : {rem_fix, quot_fix};
                done_d   = 1'b1;
                dbz_d    = bz_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_md_iterative.sv
// Scoreboard bench for md_iterative: expected results queued at start, compared on done.
module tb_md_iterative;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md_if #(.WIDTH(WIDTH)) bus ();

    md_iterative #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        dbz;
        logic [63:0] res;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic m, input logic u);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = {32'h0, a};
        ub    = {32'h0, b};
        e.dbz = 1'b0;
        if (m) begin
            e.res = u ? (ua * ub) : 64'(sa * sb);
        end else if (b == 32'h0) begin
            e.dbz = 1'b1;
            e.res = {a, 32'hFFFF_FFFF};
        end else if (u) begin
            e.res = {32'(ua % ub), 32'(ua / ub)};
        end else begin
            e.res = {32'(sa % sb), 32'(sa / sb)};
        end
        return e;
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst && bus.done) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'h0);
            end else begin
                e = sb_q.pop_front();
                check("result", bus.result, e.res);
                check("dbz_on_done", 64'(bus.div_by_zero), 64'(e.dbz));
                last_res = e.res;
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                          input logic u, input exp_t e, input int glitch_at,
                          input logic glitch_done);
        int   k;
        int   busy_cnt;
        logic stray;
        logic seen;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.a           = a;
        bus.b           = b;
        bus.is_mult     = m;
        bus.is_unsigned = u;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.a           = $urandom;
        bus.b           = $urandom;
        bus.is_mult     = ~m;
        bus.is_unsigned = ~u;
        sb_q.push_back(e);
        k        = 0;
        busy_cnt = 0;
        stray    = 1'b0;
        seen     = 1'b0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (bus.start) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (!bus.done && bus.div_by_zero) stray = 1'b1;
            if (k == 1) check("result_kept_on_start", bus.result, last_res);
            if (bus.done) seen = 1'b1;
            if (k == glitch_at || (bus.done && glitch_done)) begin
                bus.start       = 1'b1;
                bus.a           = $urandom;
                bus.b           = $urandom;
                bus.is_mult     = 1'($urandom);
                bus.is_unsigned = 1'($urandom);
            end
        end
        check("latency", 64'(k), 64'd34);
        check("busy_cycles", 64'(busy_cnt), 64'd34);
        check("dbz_outside_done", 64'(stray), 64'h0);
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_after_done", {61'h0, bus.busy, bus.done, bus.div_by_zero}, 64'h0);
        check("result_hold", bus.result, e.res);
    endtask

    function automatic exp_t mk(input logic [63:0] res, input logic dbz);
        exp_t e;
        e.res = res;
        e.dbz = dbz;
        return e;
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rm;
        logic        ru;
        rst             = 1'b0;
        bus.start       = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.is_mult     = 1'b0;
        bus.is_unsigned = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {61'h0, bus.busy, bus.done, bus.div_by_zero}, 64'h0);
        check("reset_result", bus.result, 64'h0);
        rst = 1'b1;

        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFEB, 1'b0), 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, mk(64'hFFFF_FFFE_0000_0001, 1'b0), 0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFD, 1'b0), 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(64'h0000_0000_8000_0000, 1'b0), 0, 1'b0);
        run_op(32'h0000_1234, 32'h0, 1'b0, 1'b1, mk(64'h0000_1234_FFFF_FFFF, 1'b1), 0, 1'b0);
        run_op(32'hFFFF_FFFB, 32'h0, 1'b0, 1'b0, mk(64'hFFFF_FFFB_FFFF_FFFF, 1'b1), 0, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, mk(64'h0000_0001_FFFF_FFFD, 1'b0), 0, 1'b0);
        run_op(32'd5, 32'd6, 1'b1, 1'b0, mk(64'd30, 1'b0), 10, 1'b1);

        // Abort a divide with reset mid-flight
        @(negedge clk);
        bus.start       = 1'b1;
        bus.a           = 32'd100;
        bus.b           = 32'd7;
        bus.is_mult     = 1'b0;
        bus.is_unsigned = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_flags", {61'h0, bus.busy, bus.done, bus.div_by_zero}, 64'h0);
        check("abort_result", bus.result, 64'h0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd100, 32'd7, 1'b0, 1'b1, mk(64'h0000_0002_0000_000E, 1'b0), 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom);
            rm = 1'($urandom);
            ru = 1'($urandom);
            run_op(ra, rb, rm, ru, model(ra, rb, rm, ru), 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/md_iterative.md
Name: md_iterative

Overview:
- Multi-cycle radix-2 multiply/divide engine. Replaces the combinational mult/div path.
- Sits between the register-file read ports (rs/rt operands) and the Lo/Hi register, which it feeds.
- The control unit stalls the PC while busy is high, and writes Lo/Hi on the done pulse.
- Supports mult, multu, div and divu with MIPS HI/LO semantics.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; honoured only in IDLE.
- a  input  WIDTH  operand rs (multiplicand / dividend).
- b  input  WIDTH  operand rt (multiplier / divisor).
- is_mult  input  1  1 = multiply, 0 = divide; sampled with start.
- is_unsigned  input  1  1 = unsigned, 0 = two's-complement signed; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  2*WIDTH  {HI, LO}. Multiply: full product. Divide: {remainder, quotient}.
- div_by_zero  output  1  high together with done when a divide had b == 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; busy, done, div_by_zero = 0; result = 0; counter = 0; internal accumulators = 0.
  - Reset asserted mid-operation aborts it with no done pulse.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start = 1 at edge E0:
  - Latch is_mult and is_unsigned.
  - Latch |a| and |b| (raw values if unsigned); record sign_a, sign_b.
  - Clear the accumulator, counter = 0, go to CALC.
  - busy = 1 from E0 onward.
- CALC: one iteration per edge, WIDTH iterations (edges E1..E32 for WIDTH = 32).
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half of a (2*WIDTH+1)-bit accumulator, then shift right by 1.
  - Divide: restoring. Shift {rem, quot} left by 1, trial-subtract the divisor from rem. If there is no borrow, keep the difference and set the quotient LSB to 1.
  - Counter increments each edge. When counter == WIDTH-1, go to FIX.
- FIX (edge E33): apply sign correction and register the result; go to DONE.
  - Signed multiply: negate the 2*WIDTH product if sign_a ^ sign_b.
  - Signed divide: negate the quotient if sign_a ^ sign_b; negate the remainder if sign_a (remainder takes the dividend's sign).
- DONE (cycle after E33): done = 1, busy = 1. At E34 go to IDLE; busy and done drop to 0.
- Latency: done is high exactly 34 cycles after the start edge, independent of operand values.
- result holds its value after done until the next accepted start's FIX edge. It is not cleared on start.
- start while not in IDLE is ignored; operands and mode are not re-sampled.
- start in the same cycle as DONE is ignored. A new start is accepted only from IDLE, at E34 or later.
- Divide by zero:
  - No trap; the iteration runs to completion.
  - Unsigned: quotient = all ones, remainder = a.
  - Signed: result is forced to {a, all ones}, bypassing sign correction.
  - div_by_zero = 1 for the done cycle only.
- Signed overflow, 0x80000000 / -1: quotient = 0x80000000, remainder = 0. No flag.
- |0x80000000| is represented as the unsigned value 0x80000000. Operands are WIDTH-bit unsigned magnitudes internally, so no extra bit is needed.
- Outputs are registered; there is no combinational path from the inputs to any output.

Test Plan:
- Signed mult, a = 0xFFFFFFFD (-3), b = 7 -> done at start+34, result = 0xFFFFFFFF_FFFFFFEB, div_by_zero = 0.
- multu, a = b = 0xFFFFFFFF -> result = 0xFFFFFFFE_00000001. busy is high for exactly 34 cycles; done is high for 1 cycle.
- Signed div, a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). Also a = 0x80000000, b = 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- divu, a = 0x1234, b = 0 -> result = 0x00001234_FFFFFFFF, div_by_zero = 1 during done only.
- Start mult 5*6, then pulse start with other operands at start+10 and in the DONE cycle -> both ignored; result = 30; the next start is accepted only at or after E34.
- Start divu 100/7, drive rst low at start+15 -> busy, done and result become 0 immediately. Release reset and restart -> result = {2, 14} at start+34.
